// File: rtl/div_ctrl_pkg.sv
// Shared types and widths for the divider sequencer (div_ctrl) and its helpers.
package div_ctrl_pkg;

  localparam int unsigned DIV_OP_W     = 32;
  localparam int unsigned DIV_RESULT_W = 64;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_ZERO = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

  typedef struct packed {
    logic                sgn;
    logic [DIV_OP_W-1:0] op1;
    logic [DIV_OP_W-1:0] op2;
  } div_ops_t;

  // Divide-by-zero answer: remainder = dividend, quotient = all ones.
  function automatic logic [DIV_RESULT_W-1:0] div_zero_result(input logic [DIV_OP_W-1:0] op1);
    return {op1, {DIV_OP_W{1'b1}}};
  endfunction

endpackage

// File: rtl/div_timeout_cnt.sv
// Clear/enable cycle counter with a terminal-count flag; saturates at LIMIT-1.
module div_timeout_cnt #(
  parameter int unsigned LIMIT = 40,
  parameter int unsigned CNT_W = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [CNT_W-1:0] r_cnt;

  // o_tc is high during the LIMIT-th enabled cycle since the last clear.
  assign o_tc = i_en && (r_cnt == CNT_W'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_tc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// EX-stage sequencer for the multi-cycle divider core (DIV/DIVU).
// Optional `DIV_ZERO_FAST_EN: divisor 0 bypasses the core and answers in 3 cycles.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 40
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    div_req_i,
  input  logic                    div_signed_i,
  input  logic [DIV_OP_W-1:0]     div_op1_i,
  input  logic [DIV_OP_W-1:0]     div_op2_i,
  input  logic                    flush_i,
  output logic                    stall_o,
  output logic [DIV_RESULT_W-1:0] result_o,
  output logic                    result_valid_o,
  output logic                    err_o,
  output logic                    core_start_o,
  output logic                    core_annul_o,
  output logic                    core_signed_o,
  output logic [DIV_OP_W-1:0]     core_op1_o,
  output logic [DIV_OP_W-1:0]     core_op2_o,
  input  logic [DIV_RESULT_W-1:0] core_result_i,
  input  logic                    core_ready_i
);

  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > DIV_CYCLES) ? TIMEOUT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  div_state_e               r_state;
  div_ops_t                 r_ops;
  logic [DIV_RESULT_W-1:0]  r_result;
  logic                     r_valid;
  logic                     r_err;
  logic                     r_start;
  logic                     r_annul;

  logic w_start_ok;
  logic w_cnt_en;
  logic w_cnt_clr;
  logic w_tc;

  assign w_start_ok = div_req_i & ~flush_i;
  assign w_cnt_en   = (r_state == DIV_BUSY);
  assign w_cnt_clr  = ~w_cnt_en;

  div_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES),
    .CNT_W (CNT_W)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_cnt_clr),
    .i_en  (w_cnt_en),
    .o_tc  (w_tc)
  );

  // Stall must rise in the request cycle itself, before the FSM has moved.
  assign stall_o        = ((r_state == DIV_IDLE) & w_start_ok)
                        | (r_state == DIV_BUSY)
                        | (r_state == DIV_ZERO);
  // A flush landing in DONE kills the pulse in that same cycle.
  assign result_valid_o = r_valid & ~flush_i;

  assign result_o      = r_result;
  assign err_o         = r_err;
  assign core_start_o  = r_start;
  assign core_annul_o  = r_annul;
  assign core_signed_o = r_ops.sgn;
  assign core_op1_o    = r_ops.op1;
  assign core_op2_o    = r_ops.op2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= DIV_IDLE;
      r_ops    <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_start  <= 1'b0;
      r_annul  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_annul <= 1'b0;
      case (r_state)
        DIV_IDLE: begin
          if (w_start_ok) begin
            r_ops.sgn <= div_signed_i;
            r_ops.op1 <= div_op1_i;
            r_ops.op2 <= div_op2_i;
`ifdef DIV_ZERO_FAST_EN
            if (div_op2_i == '0) begin
              r_state <= DIV_ZERO;
            end else begin
              r_start <= 1'b1;
              r_state <= DIV_BUSY;
            end
`else
            r_start <= 1'b1;
            r_state <= DIV_BUSY;
`endif
          end
        end
        DIV_BUSY: begin
          // Priority: flush, then core completion, then timeout.
          if (flush_i) begin
            r_start <= 1'b0;
            r_annul <= 1'b1;
            r_state <= DIV_IDLE;
          end else if (core_ready_i) begin
            r_result <= core_result_i;
            r_start  <= 1'b0;
            r_valid  <= 1'b1;
            r_state  <= DIV_DONE;
          end else if (w_tc) begin
            r_err   <= 1'b1;
            r_start <= 1'b0;
            r_annul <= 1'b1;
            r_state <= DIV_IDLE;
          end
        end
        DIV_ZERO: begin
          if (flush_i) begin
            r_state <= DIV_IDLE;
          end else begin
            r_result <= div_zero_result(r_ops.op1);
            r_valid  <= 1'b1;
            r_state  <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          r_state <= DIV_IDLE;
        end
        default: begin
          r_start <= 1'b0;
          r_state <= DIV_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: behavioural model + core model + directed and random stimulus.
module tb_div_ctrl;

  localparam int TIMEOUT = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        div_req_i = 1'b0;
  logic        div_signed_i = 1'b0;
  logic [31:0] div_op1_i = '0;
  logic [31:0] div_op2_i = '0;
  logic        flush_i = 1'b0;
  logic [63:0] core_result_i = '0;
  logic        core_ready_i = 1'b0;

  logic        stall_o;
  logic [63:0] result_o;
  logic        result_valid_o;
  logic        err_o;
  logic        core_start_o;
  logic        core_annul_o;
  logic        core_signed_o;
  logic [31:0] core_op1_o;
  logic [31:0] core_op2_o;

  int checks = 0;
  int failures = 0;

  div_ctrl #(.DIV_CYCLES(32), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .div_req_i      (div_req_i),
    .div_signed_i   (div_signed_i),
    .div_op1_i      (div_op1_i),
    .div_op2_i      (div_op2_i),
    .flush_i        (flush_i),
    .stall_o        (stall_o),
    .result_o       (result_o),
    .result_valid_o (result_valid_o),
    .err_o          (err_o),
    .core_start_o   (core_start_o),
    .core_annul_o   (core_annul_o),
    .core_signed_o  (core_signed_o),
    .core_op1_o     (core_op1_o),
    .core_op2_o     (core_op2_o),
    .core_result_i  (core_result_i),
    .core_ready_i   (core_ready_i)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] div_ref(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Divider core model: answers after a latency counted in cycles of start held high.
  int core_lat_fix = 32;
  bit core_hold = 1'b0;
  int ccnt = 0;
  int clat = 32;
  always @(posedge clk) begin
    #1;
    if (!core_start_o) ccnt = 0;
    else begin
      ccnt++;
      if (ccnt == 1) clat = (core_lat_fix != 0) ? core_lat_fix : int'($urandom_range(1, 38));
    end
    core_ready_i  = core_start_o && !core_hold && (ccnt == clat);
    core_result_i = core_ready_i ? div_ref(core_signed_o, core_op1_o, core_op2_o) : {$urandom, $urandom};
  end

  // Behavioural model of the sequencer, checked every cycle on the falling edge.
  bit          m_busy, m_zero, m_done, m_err, m_start, m_annul, m_sgn;
  int          m_bcyc;
  logic [31:0] m_op1, m_op2;
  logic [63:0] m_res;
  bit          last_valid, last_flush;

  always @(negedge clk) begin
    bit idle, exp_stall, exp_valid;
    if (!rst) begin
      m_busy = 0; m_zero = 0; m_done = 0; m_err = 0; m_start = 0; m_annul = 0;
      m_sgn = 0; m_bcyc = 0; m_op1 = '0; m_op2 = '0; m_res = '0;
    end
    idle      = !(m_busy || m_zero || m_done);
    exp_stall = m_busy || m_zero || (idle && div_req_i && !flush_i);
    exp_valid = m_done && !flush_i;
    chk("stall_o", stall_o, exp_stall);
    chk("result_valid_o", result_valid_o, exp_valid);
    chk("result_o", result_o, m_res);
    chk("err_o", err_o, m_err);
    chk("core_start_o", core_start_o, m_start);
    chk("core_annul_o", core_annul_o, m_annul);
    chk("core_signed_o", core_signed_o, m_sgn);
    chk("core_op1_o", core_op1_o, m_op1);
    chk("core_op2_o", core_op2_o, m_op2);
    if (exp_valid) chk("result_arith", result_o, div_ref(m_sgn, m_op1, m_op2));
    last_valid = result_valid_o;
    last_flush = flush_i;
    if (rst) begin
      m_annul = 0;
      if (m_done) m_done = 0;
      else if (m_zero) begin
        m_zero = 0;
        if (!flush_i) begin m_done = 1; m_res = {m_op1, 32'hFFFF_FFFF}; end
      end else if (m_busy) begin
        m_bcyc++;
        if (flush_i) begin m_busy = 0; m_start = 0; m_annul = 1; end
        else if (core_ready_i) begin m_res = core_result_i; m_busy = 0; m_start = 0; m_done = 1; end
        else if (m_bcyc >= TIMEOUT) begin m_err = 1; m_annul = 1; m_busy = 0; m_start = 0; end
      end else if (div_req_i && !flush_i) begin
        m_sgn = div_signed_i; m_op1 = div_op1_i; m_op2 = div_op2_i;
`ifdef DIV_ZERO_FAST_EN
        if (div_op2_i == 32'd0) m_zero = 1; else
`endif
        begin m_busy = 1; m_start = 1; m_bcyc = 0; end
      end
    end
  end

  task automatic drive(input bit req, input bit sgn, input logic [31:0] a, input logic [31:0] b, input bit fl);
    @(posedge clk); #1;
    div_req_i = req; div_signed_i = sgn; div_op1_i = a; div_op2_i = b; flush_i = fl;
  endtask

  task automatic run_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        output int stalls, output int cycles, output bit st_seen);
    bit got;
    drive(1, sgn, a, b, 0);
    stalls = 0; cycles = 0; st_seen = 0; got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      cycles++;
      if (stall_o) stalls++;
      if (core_start_o) st_seen = 1;
      if (result_valid_o) got = 1;
    end
    chk("op_completes", got, 1);
    drive(0, 0, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls, cycles;
    bit st_seen, s, nreq;
    logic [31:0] a, b;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_stall", stall_o, 0);
    chk("reset_result", result_o, 64'h0);
    chk("reset_start", core_start_o, 0);
    chk("reset_err", err_o, 0);
    @(posedge clk); #1 rst = 1'b1;

    // DIVU 100/7 with 32-cycle core
    core_lat_fix = 32;
    run_op(0, 32'd100, 32'd7, stalls, cycles, st_seen);
    chk("t1_stall_cycles", stalls, 33);
    chk("t1_latency", cycles, 34);
    chk("t1_result", result_o, {32'd2, 32'd14});

    // DIV -7/2
    run_op(1, 32'hFFFF_FFF9, 32'd2, stalls, cycles, st_seen);
    chk("t2_signed", core_signed_o, 1);
    chk("t2_result", result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    // flush at BUSY cycle 10, then DIVU 9/3
    drive(1, 0, 32'd50, 32'd5, 0);
    repeat (9) drive(1, 0, 32'd50, 32'd5, 0);
    drive(1, 0, 32'd50, 32'd5, 1);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t3_stall_after_flush", stall_o, 0);
    chk("t3_annul", core_annul_o, 1);
    chk("t3_start_dropped", core_start_o, 0);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t3_annul_one_cycle", core_annul_o, 0);
    run_op(0, 32'd9, 32'd3, stalls, cycles, st_seen);
    chk("t3_result", result_o, {32'd0, 32'd3});

    // flush coincides with core_ready
    core_lat_fix = 5;
    drive(1, 0, 32'd77, 32'd7, 0);
    repeat (4) drive(1, 0, 32'd77, 32'd7, 0);
    drive(1, 0, 32'd77, 32'd7, 1);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t4_no_valid", result_valid_o, 0);
    chk("t4_stall", stall_o, 0);
    chk("t4_result_kept", result_o, {32'd0, 32'd3});
    run_op(0, 32'd20, 32'd6, stalls, cycles, st_seen);
    chk("t4_next_op", result_o, {32'd2, 32'd3});

    // core never ready -> timeout
    core_hold = 1'b1;
    drive(1, 0, 32'd1000, 32'd3, 0);
    repeat (TIMEOUT) drive(1, 0, 32'd1000, 32'd3, 0);
    @(negedge clk);
    chk("t5_err_not_yet", err_o, 0);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t5_err_set", err_o, 1);
    chk("t5_annul", core_annul_o, 1);
    chk("t5_stall_released", stall_o, 0);
    core_hold = 1'b0;
    core_lat_fix = 3;
    run_op(0, 32'd8, 32'd2, stalls, cycles, st_seen);
    chk("t5_err_sticky", err_o, 1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_err_cleared_by_rst", err_o, 0);
    @(posedge clk); #1 rst = 1'b1;

    // reset in the middle of an operation
    core_lat_fix = 32;
    drive(1, 0, 32'd40, 32'd4, 0);
    repeat (5) drive(1, 0, 32'd40, 32'd4, 0);
    @(posedge clk); #1;
    rst = 1'b0; div_req_i = 1'b0;
    @(negedge clk);
    chk("mid_rst_start", core_start_o, 0);
    chk("mid_rst_op1", core_op1_o, 0);
    @(posedge clk); #1 rst = 1'b1;

    // divide by zero
    run_op(0, 32'd5, 32'd0, stalls, cycles, st_seen);
`ifdef DIV_ZERO_FAST_EN
    chk("t6_start_never", st_seen, 0);
    chk("t6_latency", cycles, 3);
`else
    chk("t6_start_seen", st_seen, 1);
    chk("t6_latency", cycles, 34);
`endif
    chk("t6_result", result_o, {32'd5, 32'hFFFF_FFFF});

    // random traffic, including back-to-back ops and flushes
    core_lat_fix = 0;
    repeat (3000) begin
      @(posedge clk); #1;
      flush_i = ($urandom_range(0, 29) == 0);
      if (last_valid || last_flush || !div_req_i) begin
        nreq = ($urandom_range(0, 2) != 0);
        s = $urandom_range(0, 1);
        a = $urandom;
        case ($urandom_range(0, 7))
          0:       b = 32'd0;
          1, 2:    b = $urandom_range(1, 100);
          3:       b = -$urandom_range(1, 100);
          default: b = $urandom;
        endcase
        if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
        div_req_i = nreq; div_signed_i = s; div_op1_i = a; div_op2_i = b;
      end
    end
    drive(0, 0, 0, 0, 0);
    repeat (45) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
